// File: rtl/carpark_pkg.sv
// Shared types and default sizing for the car park gate scheduler.
package carpark_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AUTH  = 2'd1,
    OPEN  = 2'd2,
    CLOSE = 2'd3
  } state_e;

  typedef enum logic {
    LANE_ENTRY = 1'b0,
    LANE_EXIT  = 1'b1
  } lane_e;

  localparam int unsigned CAPACITY_DEF     = 8;
  localparam int unsigned CNT_W_DEF        = 4;
  localparam int unsigned AUTH_TIMEOUT_DEF = 16;
  localparam int unsigned PASS_TIMEOUT_DEF = 32;

endpackage

// File: rtl/carpark_occ_counter.sv
// Up/down occupancy register with full/empty flags registered alongside the count.
module carpark_occ_counter
  import carpark_pkg::*;
#(
  parameter int unsigned CAPACITY = CAPACITY_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty
);

  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

  logic [CNT_W-1:0] occ_nxt_c;

  // Bounds are also guarded here so a stray pulse can never wrap the count.
  always_comb begin
    occ_nxt_c = occupancy;
    if (inc && !dec && (occupancy != CAP)) begin
      occ_nxt_c = occupancy + CNT_W'(1);
    end else if (dec && !inc && (occupancy != '0)) begin
      occ_nxt_c = occupancy - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
    end else begin
      occupancy <= occ_nxt_c;
      full      <= (occ_nxt_c == CAP);
      empty     <= (occ_nxt_c == '0);
    end
  end

endmodule

// File: rtl/carpark_gate_sched.sv
// Shared entrance/exit barrier scheduler: arbitration, auth, open, pass, close.
// Define CARPARK_RR_ARB_EN for round-robin arbitration; default is exit-first priority.
module carpark_gate_sched
  import carpark_pkg::*;
#(
  parameter int unsigned CAPACITY     = CAPACITY_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned AUTH_TIMEOUT = AUTH_TIMEOUT_DEF,
  parameter int unsigned PASS_TIMEOUT = PASS_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             pw_valid,
  input  logic             pw_ok,
  input  logic             pass_sensor,
  output logic             auth_start,
  output logic             gate_open,
  output logic             grant_entry,
  output logic             grant_exit,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             alarm
);

  localparam int unsigned MAX_TO = (AUTH_TIMEOUT > PASS_TIMEOUT) ? AUTH_TIMEOUT : PASS_TIMEOUT;
  localparam int unsigned WAIT_W = $clog2(MAX_TO) + 1;
  localparam logic [WAIT_W-1:0] AUTH_LAST = WAIT_W'(AUTH_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] PASS_LAST = WAIT_W'(PASS_TIMEOUT - 1);

  state_e            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              pass_q;
`ifdef CARPARK_RR_ARB_EN
  lane_e             rr_last;
`endif

  logic elig_entry_c;
  logic elig_exit_c;
  logic pick_entry_c;
  logic pass_rise_c;
  logic inc_c;
  logic dec_c;

  assign elig_entry_c = entry_req & ~full;
  assign elig_exit_c  = exit_req & ~empty;
`ifdef CARPARK_RR_ARB_EN
  // On contention the lane not served last wins.
  assign pick_entry_c = elig_entry_c & (~elig_exit_c | (rr_last == LANE_EXIT));
`else
  // On contention exit wins so space is freed first.
  assign pick_entry_c = elig_entry_c & ~elig_exit_c;
`endif

  assign pass_rise_c = pass_sensor & ~pass_q;
  assign inc_c       = (state == OPEN) & pass_rise_c & grant_entry;
  assign dec_c       = (state == OPEN) & pass_rise_c & grant_exit;

  carpark_occ_counter #(
    .CAPACITY (CAPACITY),
    .CNT_W    (CNT_W)
  ) u_occ (
    .clk       (clk),
    .rst       (rst),
    .inc       (inc_c),
    .dec       (dec_c),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      pass_q      <= 1'b0;
      auth_start  <= 1'b0;
      gate_open   <= 1'b0;
      grant_entry <= 1'b0;
      grant_exit  <= 1'b0;
      alarm       <= 1'b0;
`ifdef CARPARK_RR_ARB_EN
      rr_last     <= LANE_EXIT;
`endif
    end else begin
      pass_q     <= pass_sensor;
      auth_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_entry_c) begin
            state       <= AUTH;
            auth_start  <= 1'b1;
            grant_entry <= 1'b1;
            alarm       <= 1'b0;
            wait_cnt    <= '0;
`ifdef CARPARK_RR_ARB_EN
            rr_last     <= LANE_ENTRY;
`endif
          end else if (elig_exit_c) begin
            state      <= OPEN;
            gate_open  <= 1'b1;
            grant_exit <= 1'b1;
            alarm      <= 1'b0;
            wait_cnt   <= '0;
`ifdef CARPARK_RR_ARB_EN
            rr_last    <= LANE_EXIT;
`endif
          end
        end
        AUTH: begin
          // A password result beats the timeout landing in the same cycle.
          if (pw_valid && pw_ok) begin
            state     <= OPEN;
            gate_open <= 1'b1;
            wait_cnt  <= '0;
          end else if (pw_valid || (wait_cnt == AUTH_LAST)) begin
            state       <= IDLE;
            alarm       <= 1'b1;
            grant_entry <= 1'b0;
            wait_cnt    <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        OPEN: begin
          // After the pass timeout the gate stays open and waits for the car.
          if (pass_rise_c) begin
            state     <= CLOSE;
            gate_open <= 1'b0;
            wait_cnt  <= '0;
          end else if (wait_cnt == PASS_LAST) begin
            alarm <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        CLOSE: begin
          state       <= IDLE;
          grant_entry <= 1'b0;
          grant_exit  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/carpark_gate_sched.md
Name: carpark_gate_sched

Overview:
- Schedules one shared barrier gate between an entrance lane and an exit lane of the car park.
- Sequences authorisation, gate open, vehicle passage and gate close for each request.
- Tracks occupancy against a capacity limit.
- Sits between the lane sensors / password-check FSM and the gate actuator and status LEDs.

Parameters:
- CAPACITY, 8, maximum cars inside; entry refused at this count.
- CNT_W, 4, occupancy counter width; must satisfy 2^CNT_W > CAPACITY.
- AUTH_TIMEOUT, 16, cycles allowed in AUTH for pw_valid before the request is abandoned.
- PASS_TIMEOUT, 32, cycles allowed in OPEN for pass_sensor before the alarm is raised.

Ports:
- clk, in, 1, system clock, rising edge.
- rst, in, 1, synchronous active-high reset.
- entry_req, in, 1, car present at the entrance sensor (level).
- exit_req, in, 1, car present at the exit sensor (level).
- pw_valid, in, 1, one-cycle strobe: password result available.
- pw_ok, in, 1, password correct; sampled only when pw_valid=1.
- pass_sensor, in, 1, car has cleared the gate (level).
- auth_start, out, 1, one-cycle pulse asking the password checker to begin.
- gate_open, out, 1, barrier actuator command.
- grant_entry, out, 1, current gate owner is the entrance.
- grant_exit, out, 1, current gate owner is the exit.
- occupancy, out, CNT_W, number of cars inside.
- full, out, 1, occupancy == CAPACITY.
- empty, out, 1, occupancy == 0.
- alarm, out, 1, sticky until the next grant: auth rejected/timed out or pass timeout.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): state=IDLE, occupancy=0, empty=1, full=0, all other outputs 0, counters 0, rr_last=EXIT.
- All outputs are registered. Requests are sampled in IDLE only.
- States: IDLE, AUTH, OPEN, CLOSE.
- IDLE:
  - Eligible entry = entry_req & ~full. Eligible exit = exit_req & ~empty.
  - Exactly one eligible request: grant it.
  - Both eligible: resolve by the arbitration rule (see Optional Feature).
  - An entry grant goes to AUTH and pulses auth_start. An exit grant goes directly to OPEN.
  - A grant sets grant_entry or grant_exit and clears alarm.
- AUTH:
  - wait_cnt increments each cycle.
  - pw_valid & pw_ok goes to OPEN.
  - pw_valid & ~pw_ok, or wait_cnt == AUTH_TIMEOUT-1, goes to IDLE: alarm=1, grant dropped.
  - pw_valid takes priority over the timeout in the same cycle.
- OPEN:
  - gate_open=1; wait_cnt restarts at 0.
  - A rising edge of pass_sensor (registered compare) goes to CLOSE and updates occupancy: +1 on an entry grant, -1 on an exit grant. full/empty update in the same cycle as occupancy.
  - wait_cnt == PASS_TIMEOUT-1 with no edge: alarm=1, gate stays open and the count stops at its maximum. The state holds until the pass edge arrives; no vehicle is lost.
- CLOSE:
  - gate_open=0. Holds one cycle with the grant still asserted, then goes to IDLE with grants=0.
  - IDLE is therefore re-entered no earlier than 1 cycle after close.
- Latency: exit_req in IDLE gives gate_open on the next edge, i.e. 1 cycle.
- Occupancy is saturating by construction: entry is never granted when full, exit never when empty, so no wrap-around.
- A request de-asserted after its grant does not cancel the sequence. Only rst aborts it.
- rst mid-sequence returns to IDLE, closes the gate and clears occupancy.

Optional Feature:
- Macro: CARPARK_RR_ARB_EN.
- Defined: round-robin arbitration on simultaneous eligible requests. The lane not served last wins; rr_last updates on each grant.
- Undefined: fixed priority, exit wins, which frees space first. rr_last is not implemented.

Decomposition:
- Package carpark_pkg holds:
  - the state enum {IDLE, AUTH, OPEN, CLOSE};
  - the lane enum {LANE_ENTRY, LANE_EXIT};
  - the default CAPACITY and timeout constants.
- The password comparator and the HEX/LED display logic stay in their existing blocks.
- One natural sub-module: carpark_occ_counter, holding the up/down occupancy register plus full/empty flags, parameterised by CAPACITY and CNT_W.

Test Plan:
- Reset, then exit_req=1 with occupancy 0 -> no grant; empty=1 and gate_open=0 for 20 cycles.
- entry_req=1, pw_valid=1 and pw_ok=1 three cycles after auth_start, pass_sensor pulse -> gate_open for the OPEN window, occupancy=1, empty=0, then IDLE.
- Fill to 8 cars, then entry_req=1 -> no auth_start, full=1. Next exit_req -> occupancy=7, full=0.
- Entry with pw_ok=0 on pw_valid -> alarm=1, no gate_open, occupancy unchanged. Entry with no pw_valid for 16 cycles -> alarm=1, back to IDLE.
- entry_req and exit_req together at occupancy 3:
  - without CARPARK_RR_ARB_EN: exit granted twice in a row;
  - with CARPARK_RR_ARB_EN: grants alternate exit, entry, exit.
- In OPEN, hold pass_sensor=0 for 40 cycles -> alarm=1 at cycle 32 with the gate still open. A later pass edge gives CLOSE and the correct occupancy. A rst pulse mid-OPEN gives gate_open=0 and occupancy=0 on the next edge.
